// File: rtl/iir_notch_pkg.sv
// iir_notch_pkg: shared FSM state type, centre-frequency codes and default timing for the notch controller
package iir_notch_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, CLEAR, SETTLE} state_t;
  localparam logic FC_1MHZ = 1'b0;
  localparam logic FC_2P4MHZ = 1'b1;
  localparam int DEF_DIV = 3;
  localparam int DEF_FLUSH_SAMPLES = 4;
  localparam int DEF_SETTLE_SAMPLES = 8;
endpackage

// File: rtl/iir_notch_ctrl_strobe.sv
// sample_strobe_gen: free-running divide-by-DIV strobe; ports clk, rst in, sample_en out (high when count==DIV-1)
module sample_strobe_gen
  import iir_notch_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic sample_en
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= sample_en ? '0 : cnt + 1'b1;
  assign sample_en = cnt == CW'(DIV - 1);
endmodule

// File: rtl/iir_notch_ctrl.sv
// iir_notch_ctrl: notch filter sequencer; strobe, glitch-free centre-frequency switch (mute/flush/clear/settle), output bypass
// ports: clk, rst; cfg_valid/cfg_fc/cfg_ready request handshake; bypass; x_in, filt_out in;
//        filt_in, filt_fc, filt_clr, sample_en, x_out, busy, switch_done out
module iir_notch_ctrl
  import iir_notch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV = DEF_DIV,
  parameter int FLUSH_SAMPLES = DEF_FLUSH_SAMPLES,
  parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  input  logic                         cfg_fc,
  output logic                         cfg_ready,
  input  logic                         bypass,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] filt_out,
  output logic signed [DATA_WIDTH-1:0] filt_in,
  output logic                         filt_fc,
  output logic                         filt_clr,
  output logic                         sample_en,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         busy,
  output logic                         switch_done
);
  localparam int MAXS = FLUSH_SAMPLES > SETTLE_SAMPLES ? FLUSH_SAMPLES : SETTLE_SAMPLES;
  localparam int CW = $clog2(MAXS + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pend_fc, pend_n, done_n, accept;
  sample_strobe_gen #(.DIV(DIV)) u_strobe (.clk(clk), .rst(rst), .sample_en(sample_en));
  assign cfg_ready = state == RUN;
  assign busy = !cfg_ready;
  assign accept = cfg_valid && cfg_ready;
  assign filt_clr = state == CLEAR;
  // the filter sees silence while its old-frequency state drains, including the clear cycle
  assign filt_in = (state == FLUSH || state == CLEAR) ? '0 : x_in;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pend_n = pend_fc;
    done_n = 1'b0;
    unique case (state)
      RUN:
        if (accept) begin
          done_n = cfg_fc == filt_fc;
          if (cfg_fc != filt_fc) begin
            pend_n = cfg_fc;
            cnt_n = CW'(FLUSH_SAMPLES);
            state_n = FLUSH;
          end
        end
      FLUSH:
        if (sample_en) begin
          cnt_n = cnt - 1'b1;
          state_n = cnt == CW'(1) ? CLEAR : FLUSH;
        end
      CLEAR: begin
        cnt_n = CW'(SETTLE_SAMPLES);
        state_n = SETTLE;
      end
      SETTLE:
        if (sample_en) begin
          cnt_n = cnt - 1'b1;
          done_n = cnt == CW'(1);
          state_n = cnt == CW'(1) ? RUN : SETTLE;
        end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      pend_fc <= FC_1MHZ;
      filt_fc <= FC_1MHZ;
      x_out <= '0;
      switch_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend_fc <= pend_n;
      switch_done <= done_n;
      if (state == CLEAR) filt_fc <= pend_fc;
      if (sample_en) x_out <= bypass ? x_in : (state == RUN ? filt_out : '0);
    end
endmodule

// File: doc/iir_notch_ctrl.md
# iir_notch_ctrl

Sequencer and configuration controller for the biquad notch filter. It generates the filter's sample-rate strobe (18 MHz clock to 6 MHz samples) and owns the filter's centre-frequency select. It changes frequency glitch-free through a mute, flush, clear, settle sequence, and provides an output-side bypass. It sits between the decimated input stream and the notch filter instance, and takes centre-frequency requests from the configuration block over a valid/ready handshake.

## Interface
- DATA_WIDTH, 16, sample width (signed)
- DIV, 3, clk cycles per sample strobe (≥2)
- FLUSH_SAMPLES, 4, zero-input strobes fed before clear
- SETTLE_SAMPLES, 8, strobes output stays muted after frequency change

- clk  in  1  system clock (18 MHz); single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  centre-frequency change request
- cfg_fc  in  1  requested centre frequency: 0 = 1 MHz, 1 = 2.4 MHz
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
- bypass  in  1  1 = x_out follows x_in; filter keeps running
- x_in  in  DATA_WIDTH  input sample stream
- filt_out  in  DATA_WIDTH  notch filter output
- filt_in  out  DATA_WIDTH  notch filter input (combinational mux)
- filt_fc  out  1  filter centre-frequency select (registered)
- filt_clr  out  1  one-cycle synchronous state clear to filter
- sample_en  out  1  one-cycle sample strobe
- x_out  out  DATA_WIDTH  processed sample (registered)
- busy  out  1  frequency switch in progress
- switch_done  out  1  one-cycle pulse when a request completes

## Operation
- Strobe: the counter runs 0..DIV-1 and wraps. sample_en=1 when count==DIV-1. The counter free-runs in every state.
- FSM states: RUN, FLUSH, CLEAR, SETTLE. cfg_ready=(state==RUN). busy=(state!=RUN).
- RUN:
  - filt_in=x_in.
  - On sample_en, x_out <= bypass ? x_in : filt_out.
  - On accept with cfg_fc==filt_fc: no switch, switch_done pulses next cycle, stay in RUN.
  - On accept with cfg_fc!=filt_fc: latch pend_fc, go to FLUSH, and load the sample counter with FLUSH_SAMPLES.
- FLUSH:
  - filt_in=0.
  - On sample_en, x_out <= bypass ? x_in : 0.
  - Decrement the counter on each sample_en. The strobe that takes it to 0 moves to CLEAR.
- CLEAR (exactly one cycle):
  - filt_clr=1 and filt_fc <= pend_fc.
  - Load the counter with SETTLE_SAMPLES, go to SETTLE.
- SETTLE:
  - filt_in=x_in.
  - On sample_en, x_out <= bypass ? x_in : 0.
  - Decrement on each sample_en. The strobe reaching 0 returns to RUN and pulses switch_done on the following cycle.
- Arithmetic: no arithmetic on samples. All muxing is full-width signed; the zero sample is all-zeros.
- Boundaries:
  - A strobe on the accept cycle is still processed with RUN rules.
  - A strobe on the CLEAR cycle is ignored by the FSM. x_out still updates under FLUSH rules.
  - cfg_valid while busy is back-pressured. The requester holds cfg_valid and cfg_fc until accepted; cfg_fc is sampled only at accept.
  - bypass may toggle in any state. It takes effect at the next sample_en and never alters FSM progress.
  - FLUSH_SAMPLES or SETTLE_SAMPLES = 0 is illegal.

## Timing
- Reset values:
  - x_out=0, filt_fc=0, filt_clr=0, switch_done=0
  - sample_en=0, strobe counter=0, state=RUN
  - so cfg_ready=1 and busy=0
- Reset asserted mid-switch aborts immediately to these values, including filt_fc=0.
- First sample_en occurs on cycle DIV-1 after the rst=0 cycle, then every DIV cycles.
- x_out latency: updated at the clk edge ending the sample_en cycle. It holds between strobes.
- Switch duration (default parameters, strobe-aligned request):
  - FLUSH takes 4 strobes (12 clk).
  - CLEAR takes 1 clk.
  - SETTLE takes 8 strobes (about 24 clk).
  - switch_done follows 1 clk after the return to RUN.
- filt_fc changes only on the clock edge ending the CLEAR cycle, concurrent with filt_clr=1.

## Structure
- Package iir_notch_pkg holds:
  - FSM state enum
  - FC_1MHZ=1'b0 and FC_2P4MHZ=1'b1 constants
  - default DIV, FLUSH_SAMPLES and SETTLE_SAMPLES values
- Sub-module sample_strobe_gen: parameter DIV; ports clk, rst, sample_en.
- FSM, counters and output registers stay in iir_notch_ctrl.

## Test plan
1. Reset then idle: rst high for 5 clk, then low → sample_en pulses on cycles 2, 5, 8, ...; x_out=0, filt_fc=0, cfg_ready=1.
2. RUN passthrough: filt_out=16'sh1234 held, bypass=0 → x_out=16'sh1234 after the next strobe. Set bypass=1 with x_in=-5 → x_out=-5 at the following strobe.
3. Frequency switch: cfg_valid=1, cfg_fc=1 accepted →
   - cfg_ready=0 for the whole switch
   - filt_in=0 for 4 strobes
   - filt_clr pulse with filt_fc going 0→1
   - x_out=0 through 8 SETTLE strobes
   - switch_done pulse, cfg_ready=1, x_out tracks filt_out again
4. Same-frequency request: cfg_fc=0 while filt_fc=0 → switch_done 1 clk after accept, busy never asserted, no filt_clr.
5. Back-pressure and simultaneity:
   - a second request held during a switch is accepted only on the first cycle back in RUN
   - a request accepted on a sample_en cycle still updates x_out from filt_out on that strobe
6. Reset mid-SETTLE: assert rst during SETTLE → next cycle state=RUN, filt_fc=0, x_out=0, busy=0, no switch_done pulse.
